// File: rtl/uart_rx_os_if.sv
// Receive-word handshake between the UART receiver (master) and its consumer (slave).
interface uart_rx_os_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] dout;
  logic                 dout_valid;
  logic                 dout_ready;
  logic                 frame_err;
  logic                 parity_err;

  modport master (
    output dout, dout_valid, frame_err, parity_err,
    input  dout_ready
  );

  modport slave (
    input  dout, dout_valid, frame_err, parity_err,
    output dout_ready
  );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with a valid/ready output word and frame/parity/overrun status.
// Define UART_RX_PARITY_EN to add a parity bit between the data bits and the stop bit.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_tick,
  input  logic               rx,
  uart_rx_os_if.master       dbus,
  output logic               overrun,
  output logic               rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] TICK_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e               state_q;
  logic                 rx_meta_q;
  logic                 rx_sync_q;
  logic [CW-1:0]        tick_cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] dout_q;
  logic                 dout_valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_mis_q;
  logic                 parity_err_q;
`endif

  logic bit_end;
  logic can_load;

  // A bit period ends on the tick where the counter wraps.
  assign bit_end  = (tick_cnt_q == TICK_LAST);
  assign can_load = !dout_valid_q || dbus.dout_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_mis_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      overrun_q <= 1'b0;

      // NOTE: all state uses <=; the later reload of dout_valid_q in STOP overrides this clear.
      if (dout_valid_q && dbus.dout_ready) begin
        dout_valid_q <= 1'b0;
      end

      if (sample_tick) begin
        case (state_q)
          IDLE: begin
            if (!rx_sync_q) begin
              state_q    <= START;
              tick_cnt_q <= '0;
            end
          end
          START: begin
            if (tick_cnt_q == TICK_HALF) begin
              if (rx_sync_q) begin
                state_q <= IDLE;
              end else begin
                state_q    <= DATA;
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          DATA: begin
            if (bit_end) begin
              tick_cnt_q <= '0;
              shift_q    <= {rx_sync_q, shift_q[DATA_BITS-1:1]};
              if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (bit_end) begin
              tick_cnt_q <= '0;
              par_mis_q  <= rx_sync_q ^ (^shift_q) ^ PARITY_ODD;
              state_q    <= STOP;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
`endif
          STOP: begin
            if (bit_end) begin
              tick_cnt_q <= '0;
              state_q    <= IDLE;
              if (can_load) begin
                dout_q       <= shift_q;
                frame_err_q  <= !rx_sync_q;
                dout_valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= par_mis_q;
`endif
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign dbus.dout       = dout_q;
  assign dbus.dout_valid = dout_valid_q;
  assign dbus.frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign dbus.parity_err = parity_err_q;
`else
  assign dbus.parity_err = 1'b0;
`endif
  assign overrun = overrun_q;
  assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: randomized frames against a queue-based model of the line protocol.
module tb_uart_rx_os;
  localparam int DATA_BITS  = 8;
  localparam int OS         = 16;
  localparam bit PARITY_ODD = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sample_tick = 1'b1;
  logic rx = 1'b1;
  logic overrun;
  logic rx_busy;

  int vectors = 0;
  int miscompares = 0;

  logic [9:0] rcv_q[$];
  logic [9:0] exp_q[$];
  int ovr_cnt = 0;
  int val_run = 0;
  int val_last = 0;

  uart_rx_os_if #(.DATA_BITS(DATA_BITS)) bus ();

  uart_rx_os #(
    .DATA_BITS (DATA_BITS),
    .OVERSAMPLE(OS),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_tick(sample_tick),
    .rx         (rx),
    .dbus       (bus),
    .overrun    (overrun),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  // Observer: records accepted words, overrun cycles and dout_valid pulse widths.
  always @(negedge clk) begin
    if (bus.dout_valid && bus.dout_ready)
      rcv_q.push_back({bus.parity_err, bus.frame_err, bus.dout});
    if (overrun) ovr_cnt++;
    if (bus.dout_valid) val_run++;
    else if (val_run > 0) begin
      val_last = val_run;
      val_run  = 0;
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (OS) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Line model: start, LSB-first data, optional parity (even/odd by PARITY_ODD), stop.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_flip);
    logic pbit;
    pbit = (($countones(data) % 2) == 1) ^ PARITY_ODD ^ par_flip;
    drive_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(pbit);
`endif
    drive_bit(stop_bit);
  endtask

  task automatic expect_frame(input logic [7:0] data, input logic stop_bit, input logic par_flip);
    logic pe;
`ifdef UART_RX_PARITY_EN
    pe = par_flip;
`else
    pe = 1'b0;
`endif
    exp_q.push_back({pe, !stop_bit, data});
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (bus.dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout: got %h expected 00", bus.dout); end
    vectors++; if (bus.dout_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", bus.dout_valid); end
    vectors++; if (bus.frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
    vectors++; if (bus.parity_err !== 1'b0) begin miscompares++; $display("FAIL reset_parity_err: got %b expected 0", bus.parity_err); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    vectors++; if (rx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
    rst = 1'b1;
    idle(4);
  endtask

  task automatic test_single();
    rcv_q.delete(); exp_q.delete(); ovr_cnt = 0; val_last = 0;
    send_frame(8'hA5, 1'b1, 1'b0);
    expect_frame(8'hA5, 1'b1, 1'b0);
    idle(2 * OS);
    vectors++; if (rcv_q.size() != exp_q.size()) begin miscompares++; $display("FAIL single_count: got %0d expected %0d", rcv_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
      vectors++; if (rcv_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL single_word: got %h expected %h", rcv_q[i], exp_q[i]); end
    end
    vectors++; if (val_last !== 1) begin miscompares++; $display("FAIL single_valid_width: got %0d expected 1", val_last); end
    vectors++; if (ovr_cnt !== 0) begin miscompares++; $display("FAIL single_overrun: got %0d expected 0", ovr_cnt); end
  endtask

  task automatic test_false_start();
    int busy_cnt = 0;
    rcv_q.delete();
    rx = 1'b0;
    for (int i = 0; i < 3 * OS; i++) begin
      @(negedge clk);
      if (rx_busy) busy_cnt++;
      @(posedge clk);
      #1;
      if (i == 3) rx = 1'b1;
    end
    vectors++; if (busy_cnt < 1 || busy_cnt > OS / 2) begin miscompares++; $display("FAIL false_start_busy_cycles: got %0d expected 1..%0d", busy_cnt, OS / 2); end
    vectors++; if (rx_busy !== 1'b0) begin miscompares++; $display("FAIL false_start_busy_end: got %b expected 0", rx_busy); end
    vectors++; if (rcv_q.size() != 0) begin miscompares++; $display("FAIL false_start_words: got %0d expected 0", rcv_q.size()); end
  endtask

  task automatic test_frame_err();
    rcv_q.delete(); exp_q.delete();
    send_frame(8'h3C, 1'b0, 1'b0);
    expect_frame(8'h3C, 1'b0, 1'b0);
    idle(3 * OS);
    vectors++; if (rcv_q.size() != exp_q.size()) begin miscompares++; $display("FAIL frame_err_count: got %0d expected %0d", rcv_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
      vectors++; if (rcv_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL frame_err_word: got %h expected %h", rcv_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overrun();
    rcv_q.delete(); ovr_cnt = 0;
    bus.dout_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    idle(2 * OS);
    vectors++; if (bus.dout !== 8'h11) begin miscompares++; $display("FAIL overrun_dout: got %h expected 11", bus.dout); end
    vectors++; if (bus.dout_valid !== 1'b1) begin miscompares++; $display("FAIL overrun_valid_held: got %b expected 1", bus.dout_valid); end
    vectors++; if (ovr_cnt !== 1) begin miscompares++; $display("FAIL overrun_pulse_cycles: got %0d expected 1", ovr_cnt); end
    vectors++; if (rcv_q.size() != 0) begin miscompares++; $display("FAIL overrun_early_accept: got %0d expected 0", rcv_q.size()); end
    bus.dout_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if (bus.dout_valid !== 1'b0) begin miscompares++; $display("FAIL overrun_valid_drop: got %b expected 0", bus.dout_valid); end
    vectors++; if (rcv_q.size() != 1) begin miscompares++; $display("FAIL overrun_accept_count: got %0d expected 1", rcv_q.size()); end
    else begin
      vectors++; if (rcv_q[0] !== 10'h011) begin miscompares++; $display("FAIL overrun_accept_word: got %h expected 011", rcv_q[0]); end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    rcv_q.delete(); exp_q.delete();
    send_frame(8'h07, 1'b1, 1'b0);
    expect_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    expect_frame(8'h07, 1'b1, 1'b1);
    idle(2 * OS);
    vectors++; if (rcv_q.size() != exp_q.size()) begin miscompares++; $display("FAIL parity_count: got %0d expected %0d", rcv_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
      vectors++; if (rcv_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL parity_word%0d: got %h expected %h", i, rcv_q[i], exp_q[i]); end
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [7:0] d;
    logic       flip;
    rcv_q.delete(); exp_q.delete(); ovr_cnt = 0;
    for (int n = 0; n < 8; n++) begin
      d = 8'($urandom_range(0, 255));
`ifdef UART_RX_PARITY_EN
      flip = 1'($urandom_range(0, 1));
`else
      flip = 1'b0;
`endif
      send_frame(d, 1'b1, flip);
      expect_frame(d, 1'b1, flip);
    end
    idle(2 * OS);
    vectors++; if (rcv_q.size() != exp_q.size()) begin miscompares++; $display("FAIL b2b_count: got %0d expected %0d", rcv_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
      vectors++; if (rcv_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL b2b_word%0d: got %h expected %h", i, rcv_q[i], exp_q[i]); end
    end
    vectors++; if (ovr_cnt !== 0) begin miscompares++; $display("FAIL b2b_overrun: got %0d expected 0", ovr_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    rcv_q.delete(); exp_q.delete(); ovr_cnt = 0;
    d = 8'($urandom_range(0, 255));
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rst = 1'b0;
    rx  = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if (bus.dout !== 8'h00) begin miscompares++; $display("FAIL midrst_dout: got %h expected 00", bus.dout); end
    vectors++; if (bus.dout_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b expected 0", bus.dout_valid); end
    vectors++; if (bus.frame_err !== 1'b0) begin miscompares++; $display("FAIL midrst_frame_err: got %b expected 0", bus.frame_err); end
    vectors++; if (bus.parity_err !== 1'b0) begin miscompares++; $display("FAIL midrst_parity_err: got %b expected 0", bus.parity_err); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL midrst_overrun: got %b expected 0", overrun); end
    vectors++; if (rx_busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", rx_busy); end
    rst = 1'b1;
    idle(3 * OS);
    vectors++; if (rcv_q.size() != 0) begin miscompares++; $display("FAIL midrst_words: got %0d expected 0", rcv_q.size()); end
    send_frame(8'h5A, 1'b1, 1'b0);
    expect_frame(8'h5A, 1'b1, 1'b0);
    idle(2 * OS);
    vectors++; if (rcv_q.size() != exp_q.size()) begin miscompares++; $display("FAIL midrst_next_count: got %0d expected %0d", rcv_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
      vectors++; if (rcv_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL midrst_next_word: got %h expected %h", rcv_q[i], exp_q[i]); end
    end
    vectors++; if (ovr_cnt !== 0) begin miscompares++; $display("FAIL midrst_overrun_count: got %0d expected 0", ovr_cnt); end
  endtask

  initial begin
    bus.dout_ready = 1'b1;
    test_reset();
    test_single();
    test_false_start();
    test_frame_err();
    test_overrun();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
